ex_issue_stage: RTL
===================

# ex_issue_stage

ID/EX issue register that sits directly upstream of the ALU and drives its Data1/Data2/op/imm inputs. It captures decoded instructions and resolves read-after-write hazards by forwarding from the MEM and WB stages. When forwarding cannot supply a value in time, it stalls decode and inserts bubbles. It also applies branch flushes and keeps a saturating stall counter for performance bring-up.

## Interface
- DSIZE, 16, datapath width; must equal the ALU width
- RSIZE, 4, register-address width; register 0 is hard zero
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous, active-low
- id_valid / id_ready  in / out  1 / 1  decode handshake; an instruction transfers when both are high at an edge
- id_op  in  4  opcode (shared package encoding)
- id_rs, id_rt, id_rd  in  RSIZE  source A, source B / store-source, destination
- id_rs_used, id_rt_used, id_we  in  1  source-read enables, destination-write enable
- id_rdata1, id_rdata2  in  DSIZE  register-file read data for rs, rt
- id_use_imm  in  1  Data2 takes id_immval; the forwarded rt value goes to ex_store_data
- id_immval  in  DSIZE  sign/zero-extended immediate; id_imm  in  4  shift amount
- mem_rd, mem_we, mem_is_load  in  RSIZE,1,1  sideband shadowing the ALU output register
- mem_result  in  DSIZE  ALU Out
- wb_rd, wb_we  in  RSIZE,1; wb_data  in  DSIZE  write-back stage
- flush  in  1  kill the instruction entering EX
- ex_valid  out  1; ex_op  out  4; ex_data1, ex_data2, ex_store_data  out  DSIZE; ex_imm  out  4
- ex_rd  out  RSIZE; ex_we, ex_is_load  out  1
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Hazard check per used source s (rs or rt), only when s≠0, in priority order:
  1. EX hit: ex_valid & ex_we & ex_rd==s. Stall, because the ALU result is not registered yet.
  2. MEM hit with mem_is_load: stall.
  3. MEM hit without load: forward mem_result.
  4. WB hit: forward wb_data.
  5. Otherwise use id_rdata.
- A source of 0 reads as 0 and is never forwarded or stalled.
- stall = id_valid & any source hazard & ~flush; id_ready = ~stall.
- At each edge:
  - flush: bubble loaded, decode input dropped (id_ready=1).
  - Else stall: bubble loaded.
  - Else id_valid: instruction loaded with forwarded operands.
  - Else: bubble loaded.
- Bubble: ex_valid=0, ex_op=NOP_OP (4'b1111, which leaves ALU flags untouched), ex_we=0, ex_is_load=0, data 0.
- ex_is_load = (id_op==LW_OP).
- ex_data2 = id_use_imm ? id_immval : forwarded rt; ex_store_data = forwarded rt.
- stall_cnt increments on every stall cycle and holds at 16'hFFFF.
- Reset values: ex_valid 0, ex_op 4'b1111, all data/rd/imm 0, ex_we 0, ex_is_load 0, stall_cnt 0. id_ready is combinational: 1 while reset is asserted.

## Timing
- One cycle from handshake to ex_* outputs; the ALU result appears one cycle later on mem_result.
- Back-to-back dependent ALU ops: 1 stall cycle. Load followed by a dependent instruction at distance 1: 2 stalls. At distance 2: 1 stall.
- Simultaneous flush and stall: flush wins; stall_cnt does not increment.
- rst_n low at any time clears all registers immediately, regardless of clock.

## Configuration
- FWD_EN defined: forwarding paths as above.
- FWD_EN undefined: no forwarding muxes. Any EX, MEM or WB hit stalls until the writer retires. Dependent ALU ops stall 3 cycles.

## Structure
- Shared package (define.v): DSIZE, RSIZE, opcodes (ADD 0, SUB 1, AND 2, OR 3, LW 8, SW 9, LLB 11, NOP_OP 15).
- Sub-module fwd_mux: per-source hit compare and select, returning {stall, value}. Instantiated twice (rs, rt).

## Test plan
- ADD r1,r2,r3 then SUB r4,r1,r5 with r2=5, r3=7 -> one stall (id_ready low 1 cycle); SUB sees ex_data1=12 forwarded from mem_result; stall_cnt=1.
- LW r6 then AND r7,r6,r6 with wb_data=16'hA5A5 -> two bubbles; ex_data1=ex_data2=16'hA5A5.
- Distance-3 dependency, wb_data=16'h0042, stale rdata1=0 -> no stall; ex_data1=16'h0042.
- Source r0 while EX writes rd=0 -> no stall; operand 0.
- flush asserted during stall -> bubble; id_ready=1; stall_cnt unchanged; ex_op=4'b1111.
- Force 70000 stall cycles -> stall_cnt=16'hFFFF. Then rst_n low mid-clock -> all outputs reset immediately.

Source files
------------

// File: rtl/ex_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_stage_pkg
// Purpose  : Shared widths and opcode encoding for the ID/EX issue stage.
// Revision : 1.0 - initial release
// ============================================================================
package ex_issue_stage_pkg;

    localparam int DSIZE = 16;
    localparam int RSIZE = 4;

    typedef enum logic [3:0] {
        ADD_OP = 4'd0,
        SUB_OP = 4'd1,
        AND_OP = 4'd2,
        OR_OP  = 4'd3,
        LW_OP  = 4'd8,
        SW_OP  = 4'd9,
        LLB_OP = 4'd11,
        NOP_OP = 4'd15
    } op_e;

endpackage
`default_nettype wire

// File: rtl/ex_issue_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_stage_fwd_mux
// Purpose  : Per-source RAW hazard compare and operand select, {stall, value}.
//            FWD_EN selects forwarding; otherwise any in-flight writer stalls.
// Revision : 1.0 - initial release
// ============================================================================
module ex_issue_stage_fwd_mux
    import ex_issue_stage_pkg::*;
(
    input  logic             i_used,
    input  logic [RSIZE-1:0] i_src,
    input  logic [DSIZE-1:0] i_rdata,
    input  logic             i_ex_valid,
    input  logic             i_ex_we,
    input  logic [RSIZE-1:0] i_ex_rd,
    input  logic [RSIZE-1:0] i_mem_rd,
    input  logic             i_mem_we,
    input  logic             i_mem_is_load,
    input  logic [DSIZE-1:0] i_mem_result,
    input  logic [RSIZE-1:0] i_wb_rd,
    input  logic             i_wb_we,
    input  logic [DSIZE-1:0] i_wb_data,
    output logic [DSIZE:0]   o_fwd
);

    logic             w_nz;
    logic             w_ex_hit;
    logic             w_mem_hit;
    logic             w_wb_hit;
    logic             w_stall;
    logic [DSIZE-1:0] w_value;

    assign w_nz      = (i_src != '0);
    assign w_ex_hit  = w_nz & i_ex_valid & i_ex_we & (i_ex_rd == i_src);
    assign w_mem_hit = w_nz & i_mem_we & (i_mem_rd == i_src);
    assign w_wb_hit  = w_nz & i_wb_we & (i_wb_rd == i_src);

`ifdef FWD_EN
    // An EX writer or a load sitting in MEM has no value available yet.
    assign w_stall = i_used & (w_ex_hit | (w_mem_hit & i_mem_is_load));

    always_comb begin
        w_value = i_rdata;
        if (!w_nz) begin
            w_value = '0;
        end else if (w_mem_hit) begin
            w_value = i_mem_result;
        end else if (w_wb_hit) begin
            w_value = i_wb_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_mem_is_load, i_mem_result, i_wb_data};

    assign w_stall = i_used & (w_ex_hit | w_mem_hit | w_wb_hit);
    assign w_value = w_nz ? i_rdata : '0;
`endif

    assign o_fwd = {w_stall, w_value};

endmodule
`default_nettype wire

// File: rtl/ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_stage
// Purpose  : ID/EX issue register with RAW forwarding/stall, flush and a
//            saturating stall counter. Macro FWD_EN enables forwarding paths.
// Revision : 1.0 - initial release
// ============================================================================
module ex_issue_stage
    import ex_issue_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_id_valid,
    output logic             o_id_ready,
    input  logic [3:0]       i_id_op,
    input  logic [RSIZE-1:0] i_id_rs,
    input  logic [RSIZE-1:0] i_id_rt,
    input  logic [RSIZE-1:0] i_id_rd,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic             i_id_we,
    input  logic [DSIZE-1:0] i_id_rdata1,
    input  logic [DSIZE-1:0] i_id_rdata2,
    input  logic             i_id_use_imm,
    input  logic [DSIZE-1:0] i_id_immval,
    input  logic [3:0]       i_id_imm,
    input  logic [RSIZE-1:0] i_mem_rd,
    input  logic             i_mem_we,
    input  logic             i_mem_is_load,
    input  logic [DSIZE-1:0] i_mem_result,
    input  logic [RSIZE-1:0] i_wb_rd,
    input  logic             i_wb_we,
    input  logic [DSIZE-1:0] i_wb_data,
    input  logic             i_flush,
    output logic             o_ex_valid,
    output logic [3:0]       o_ex_op,
    output logic [DSIZE-1:0] o_ex_data1,
    output logic [DSIZE-1:0] o_ex_data2,
    output logic [DSIZE-1:0] o_ex_store_data,
    output logic [3:0]       o_ex_imm,
    output logic [RSIZE-1:0] o_ex_rd,
    output logic             o_ex_we,
    output logic             o_ex_is_load,
    output logic [15:0]      o_stall_cnt
);

    logic [DSIZE:0]   w_fwd_rs;
    logic [DSIZE:0]   w_fwd_rt;
    logic             w_stall;
    logic             w_load;

    logic             r_ex_valid;
    logic [3:0]       r_ex_op;
    logic [DSIZE-1:0] r_ex_data1;
    logic [DSIZE-1:0] r_ex_data2;
    logic [DSIZE-1:0] r_ex_store_data;
    logic [3:0]       r_ex_imm;
    logic [RSIZE-1:0] r_ex_rd;
    logic             r_ex_we;
    logic             r_ex_is_load;
    logic [15:0]      r_stall_cnt;

    ex_issue_stage_fwd_mux u_fwd_rs (
        .i_used        (i_id_rs_used),
        .i_src         (i_id_rs),
        .i_rdata       (i_id_rdata1),
        .i_ex_valid    (r_ex_valid),
        .i_ex_we       (r_ex_we),
        .i_ex_rd       (r_ex_rd),
        .i_mem_rd      (i_mem_rd),
        .i_mem_we      (i_mem_we),
        .i_mem_is_load (i_mem_is_load),
        .i_mem_result  (i_mem_result),
        .i_wb_rd       (i_wb_rd),
        .i_wb_we       (i_wb_we),
        .i_wb_data     (i_wb_data),
        .o_fwd         (w_fwd_rs)
    );

    ex_issue_stage_fwd_mux u_fwd_rt (
        .i_used        (i_id_rt_used),
        .i_src         (i_id_rt),
        .i_rdata       (i_id_rdata2),
        .i_ex_valid    (r_ex_valid),
        .i_ex_we       (r_ex_we),
        .i_ex_rd       (r_ex_rd),
        .i_mem_rd      (i_mem_rd),
        .i_mem_we      (i_mem_we),
        .i_mem_is_load (i_mem_is_load),
        .i_mem_result  (i_mem_result),
        .i_wb_rd       (i_wb_rd),
        .i_wb_we       (i_wb_we),
        .i_wb_data     (i_wb_data),
        .o_fwd         (w_fwd_rt)
    );

    // Gating with rst_n keeps id_ready high while reset is held.
    assign w_stall    = rst_n & i_id_valid & (w_fwd_rs[DSIZE] | w_fwd_rt[DSIZE]) & ~i_flush;
    assign o_id_ready = ~w_stall;
    assign w_load     = i_id_valid & ~w_stall & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_op         <= NOP_OP;
            r_ex_data1      <= '0;
            r_ex_data2      <= '0;
            r_ex_store_data <= '0;
            r_ex_imm        <= '0;
            r_ex_rd         <= '0;
            r_ex_we         <= 1'b0;
            r_ex_is_load    <= 1'b0;
        end else if (w_load) begin
            r_ex_valid      <= 1'b1;
            r_ex_op         <= i_id_op;
            r_ex_data1      <= w_fwd_rs[DSIZE-1:0];
            r_ex_data2      <= i_id_use_imm ? i_id_immval : w_fwd_rt[DSIZE-1:0];
            r_ex_store_data <= w_fwd_rt[DSIZE-1:0];
            r_ex_imm        <= i_id_imm;
            r_ex_rd         <= i_id_rd;
            r_ex_we         <= i_id_we;
            r_ex_is_load    <= (i_id_op == LW_OP);
        end else begin
            r_ex_valid      <= 1'b0;
            r_ex_op         <= NOP_OP;
            r_ex_data1      <= '0;
            r_ex_data2      <= '0;
            r_ex_store_data <= '0;
            r_ex_imm        <= '0;
            r_ex_rd         <= '0;
            r_ex_we         <= 1'b0;
            r_ex_is_load    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_ex_valid      = r_ex_valid;
    assign o_ex_op         = r_ex_op;
    assign o_ex_data1      = r_ex_data1;
    assign o_ex_data2      = r_ex_data2;
    assign o_ex_store_data = r_ex_store_data;
    assign o_ex_imm        = r_ex_imm;
    assign o_ex_rd         = r_ex_rd;
    assign o_ex_we         = r_ex_we;
    assign o_ex_is_load    = r_ex_is_load;
    assign o_stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire
